// File: rtl/ps2_host_tx_if.sv
// Command handshake between a byte source and the PS/2 host transmitter.
// The source offers tx_data with tx_valid; the transmitter reports status.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send,
// then shifts an odd-parity frame out on device clock falls and checks ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [20:0]   TMO_LAST = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_s;
    logic          data_s;
    logic          filt_q, filt_d;
    logic          fall_q, fall_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    state_t        state_q, state_d;
    logic [10:0]   frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [20:0]   tmo_q, tmo_d;
    logic          ack_q, ack_d;
    logic          samp_q, samp_d;

    logic          timed;
    logic          tmo_hit;
    logic          ready_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          clk_oe_o;
    logic          data_oe_o;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronizers; the idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // Filtered clock flips only after FILTER_LEN agreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall_d = 1'b0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FLT_LAST) begin
                filt_d = clk_s;
                fall_d = ~clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Glitch filter state and the registered fall strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
        end
    end

    // Next state, counters and Mealy outputs of the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        ack_d     = ack_q;
        samp_d    = samp_q;
        ready_o   = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        err_o     = 1'b0;
        clk_oe_o  = 1'b0;
        data_oe_o = 1'b0;
        timed     = (state_q == SEND) || (state_q == ACK) ||
                    (state_q == WAIT_IDLE);
        tmo_hit   = timed && !fall_q && (tmo_q == TMO_LAST);
        if (timed) begin
            tmo_d = fall_q ? '0 : tmo_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                tmo_d   = '0;
                if (tx.tx_valid) begin
                    frame_d = {1'b1, ~^tx.tx_data, tx.tx_data, 1'b0};
                    inh_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_o = 1'b1;
                if (inh_q == INH_LAST) begin
                    state_d = REQ;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            REQ: begin
                clk_oe_o  = 1'b1;
                data_oe_o = 1'b1;
                bit_d     = '0;
                tmo_d     = '0;
                state_d   = SEND;
            end
            SEND: begin
                data_oe_o = ~frame_q[bit_q];
                if (fall_q) begin
                    if (bit_q == 4'd10) begin
                        samp_d  = data_s;
                        state_d = ACK;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ACK: begin
                ack_d   = ~samp_q;
                err_o   = samp_q;
                state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (filt_q && data_s) begin
                    done_o  = ack_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (tmo_hit) begin
            clk_oe_o  = 1'b0;
            data_oe_o = 1'b0;
            done_o    = 1'b0;
            err_o     = 1'b1;
            state_d   = IDLE;
        end
    end

    // Sequencer registers; reset returns straight to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            bit_q   <= '0;
            inh_q   <= '0;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            samp_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            inh_q   <= inh_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
            samp_q  <= samp_d;
        end
    end

    assign tx.tx_ready = ready_o;
    assign tx.busy     = busy_o;
    assign tx.done     = done_o;
    assign tx.err      = err_o;
    assign ps2_clk_oe  = clk_oe_o;
    assign ps2_data_oe = data_oe_o;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and a per-cycle monitor checks the line-drive timing rules.
module tb_ps2_host_tx;
    localparam int INH = 100;
    localparam int TMO = 3000;
    localparam int FLT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic bus_clk;
    logic bus_data;

    int checks = 0;
    int failures = 0;

    ps2_host_tx_if tx ();

    assign bus_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign bus_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(FLT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx(tx),
        .ps2_clk_in(bus_clk),
        .ps2_data_in(bus_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame the device must observe: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    int   k = 0;
    bit   acc_seen = 0;
    int   oe_hi = 0;
    int   done_n = 0;
    int   err_n = 0;
    int   err_k = -1;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    // Per-cycle monitor; k counts cycles since the last acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            acc_seen  = 0;
            k         = 0;
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            k++;
            if (tx.tx_valid && tx.tx_ready) begin
                k        = 0;
                acc_seen = 1;
                oe_hi    = 0;
            end
            if (ps2_clk_oe) oe_hi++;
            check("clk_oe_window", ps2_clk_oe,
                  acc_seen && k >= 1 && k <= INH + 1);
            if (acc_seen && k >= 1 && k <= INH + 1)
                check("data_oe_req", ps2_data_oe, k == INH + 1);
            if (acc_seen && k >= 1 && k <= INH + 2)
                check("busy_frame", tx.busy, 1);
            check("ready_vs_busy", tx.tx_ready, !tx.busy);
            if (tx.tx_ready) check("idle_data_oe", ps2_data_oe, 0);
            if (prev_done) check("ready_after_done", tx.tx_ready, 1);
            if (tx.done || tx.err) begin
                check("oe_at_end", {ps2_clk_oe, ps2_data_oe}, 0);
                check("end_pulse_width", prev_done | prev_err, 0);
            end
            check("done_err_excl", tx.done & tx.err, 0);
            if (tx.done) done_n++;
            if (tx.err) begin
                err_n++;
                err_k = k;
            end
            prev_done = tx.done;
            prev_err  = tx.err;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device: waits for request, then produces nfalls clock falls, sampling
    // the bus before each fall and optionally acking the 11th.
    task automatic device(input int nfalls, input bit ack, input bit glitch,
                          input bit midv, output logic [10:0] got);
        int n;
        got = '0;
        n = 0;
        while (ps2_clk_oe && n < INH + 20) begin
            wait_cycles(1);
            n++;
        end
        check("inhibit_release", ps2_clk_oe, 0);
        if (ps2_clk_oe) return;
        wait_cycles($urandom_range(20, 60));
        for (int i = 0; i < nfalls; i++) begin
            got[i] = bus_data;
            if (i == 10) begin
                dev_data_low = ack;
                wait_cycles(5);
            end
            dev_clk_low = 1'b1;
            wait_cycles($urandom_range(30, 70));
            dev_clk_low = 1'b0;
            if (glitch && i == 3) begin
                wait_cycles(10);
                dev_clk_low = 1'b1;
                wait_cycles(3);
                dev_clk_low = 1'b0;
            end
            if (midv && i == 4) begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = 8'hAA;
                wait_cycles(4);
                tx.tx_valid = 1'b0;
            end
            wait_cycles($urandom_range(30, 70));
        end
        dev_data_low = 1'b0;
    endtask

    task automatic offer(input logic [7:0] b);
        check("ready_before_offer", tx.tx_ready, 1);
        tx.tx_data  = b;
        tx.tx_valid = 1'b1;
        wait_cycles(1);
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'($urandom);
    endtask

    // mode 0: ack, 1: nack, 2: glitch plus mid-frame request.
    task automatic xfer(input logic [7:0] b, input int mode,
                        output logic [10:0] got);
        int d0, e0, n;
        d0 = done_n;
        e0 = err_n;
        offer(b);
        device(11, mode != 1, mode == 2, mode == 2, got);
        n = 0;
        while (done_n == d0 && err_n == e0 && n < 500) begin
            wait_cycles(1);
            n++;
        end
        n = 0;
        while (!tx.tx_ready && n < 500) begin
            wait_cycles(1);
            n++;
        end
        wait_cycles(20);
        check("frame_bits", got, frame_of(b));
        check("done_count", done_n - d0, (mode != 1) ? 1 : 0);
        check("err_count", err_n - e0, (mode == 1) ? 1 : 0);
        check("back_to_idle", tx.tx_ready, 1);
    endtask

    initial begin
        logic [10:0] got;
        int e0, n;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        #1;
        check("rst_ready", tx.tx_ready, 1);
        check("rst_busy", tx.busy, 0);
        check("rst_done_err", {tx.done, tx.err}, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(3);

        check("model_ed", frame_of(8'hED), 11'h7DA);
        xfer(8'hED, 0, got);
        check("ed_frame", got, 11'h7DA);

        xfer(8'hF4, 0, got);
        check("f4_parity", got[9], 0);
        check("f4_clk_oe_len", oe_hi, INH + 1);

        e0 = err_n;
        offer(8'h5A);
        n = 0;
        while (err_n == e0 && n < INH + TMO + 100) begin
            wait_cycles(1);
            n++;
        end
        check("tmo_err", err_n - e0, 1);
        check("tmo_latency", err_k, INH + 1 + TMO);
        check("tmo_ready", tx.tx_ready, 1);
        check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        wait_cycles(5);

        xfer(8'h3C, 1, got);
        xfer(8'($urandom), 2, got);

        offer(8'hF4);
        device(5, 1'b0, 1'b0, 1'b0, got);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("midrst_ready", tx.tx_ready, 1);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(2);
        check("postrst_ready", tx.tx_ready, 1);
        xfer(8'hF4, 0, got);
        check("postrst_f4", got, frame_of(8'hF4));

        for (int r = 0; r < 5; r++) xfer(8'($urandom), 0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter, the sending side of the keyboard link that `KeyboardDecoder` receives on. It drives `PS2_CLK`/`PS2_DATA` low through open-drain enables to send command bytes to the keyboard, such as 0xED (set LEDs) or 0xF4 (enable scanning). It sits beside the decoder in `top`. The top level builds the tristates as `PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz` and `PS2_DATA = ps2_data_oe ? 1'b0 : 1'bz`. `top` holds the decoder idle while `busy` is high.

## Interface
Parameters:
- INHIBIT_CYCLES, default 10000: clock-inhibit length; 100 µs at 100 MHz.
- TIMEOUT_CYCLES, default 2000000: maximum cycles allowed between device clock falls; 20 ms.
- FILTER_LEN, default 8: consecutive equal samples required before the filtered `ps2_clk` changes.

Ports:
- clk, in, 1: 100 MHz system clock. This is the only clock.
- rst, in, 1: asynchronous, active-low reset.
- tx_valid, in, 1: a byte is offered for sending.
- tx_data, in, 8: the byte to send.
- tx_ready, out, 1: high only in IDLE.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a transfer was acknowledged and the bus has returned to idle.
- err, out, 1: one-cycle pulse on timeout or NACK.
- ps2_clk_in, in, 1: raw PS2_CLK pin.
- ps2_data_in, in, 1: raw PS2_DATA pin.
- ps2_clk_oe, out, 1: 1 pulls PS2_CLK low.
- ps2_data_oe, out, 1: 1 pulls PS2_DATA low.

## Operation
- **Input conditioning:**
  - Both pins pass through a 2-flop synchronizer.
  - The `ps2_clk` path adds a FILTER_LEN-sample glitch filter.
  - `fall` is a one-cycle strobe for a filtered 1→0 transition.
- **Frame:** 11-bit word `{stop=1, parity, d7..d0, start=0}`.
  - parity = ~^tx_data, giving odd parity.
  - Data is latched at acceptance.
  - Bits are sent LSB first.
- **Line drive:** `ps2_data_oe = ~current_bit` while transmitting. A 0 pulls the line low; a 1 releases it.
- **FSM states:**
  - **IDLE:**
    - tx_ready=1, both oe=0.
    - `tx_valid` is accepted in this state; go to INHIBIT and latch the frame.
  - **INHIBIT:**
    - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - **REQ:**
    - Lasts 1 cycle, with ps2_clk_oe=1 and ps2_data_oe=1 (start bit).
    - Then go to SEND; reset the bit counter to 0 and the timeout counter to 0.
  - **SEND:**
    - ps2_clk_oe=0.
    - On each `fall`, bitcnt increments.
    - bitcnt 1..8 drives d0..d7, bitcnt 9 drives parity, bitcnt 10 drives stop (releases the line).
    - At the 11th `fall`, go to ACK.
  - **ACK:**
    - Samples the synchronized `ps2_data` in the same cycle as that `fall`; both oe=0.
    - If the sample is 0, go to WAIT_IDLE with ack flag set.
    - If the sample is 1 (NACK), pulse `err` and go to WAIT_IDLE with ack flag clear.
  - **WAIT_IDLE:**
    - Wait until filtered clk=1 and synchronized data=1 together.
    - Then pulse `done` if the ack flag is set, and go to IDLE.
- **Timeout:**
  - A 21-bit counter runs in SEND, ACK and WAIT_IDLE; it is cleared on every `fall`.
  - On reaching TIMEOUT_CYCLES: release both oe, pulse `err`, go to IDLE.
  - `done` is not pulsed on timeout.
- **Illegal or unexpected input:**
  - `tx_valid` outside IDLE is ignored; the byte is not queued.
  - `tx_data` changes after acceptance have no effect.
- **Reset:**
  - Asserting `rst` (low) at any time, including mid-frame, immediately forces IDLE.
  - All outputs go to their reset values; the counters clear.

## Timing
- **Reset values:**
  - tx_ready=1
  - busy=0, done=0, err=0
  - ps2_clk_oe=0, ps2_data_oe=0
- **Acceptance:** occurs on the rising edge where tx_valid & tx_ready are both high. ps2_clk_oe and busy are 1 on the next cycle.
- **Clock inhibit:** ps2_clk_oe stays high for INHIBIT_CYCLES+1 cycles (INHIBIT plus REQ). ps2_data_oe rises in the REQ cycle.
- **Edge latency:** `fall` lags the pin by 2 + FILTER_LEN cycles. `ps2_data_oe` updates on the cycle after `fall`, well inside the device's low phase (≥30 µs).
- **Completion:** `done` or `err` asserts for exactly one cycle. In the case of `done`, tx_ready returns to 1 on the following cycle.
- **Simultaneous events:** if a timeout coincides with `fall`, `fall` wins and the counter clears.

## Test plan
- **0xED with ACKing device model** (10 kHz clock):
  - Sampled data sequence must be 0,1,0,1,1,0,1,1,1,1(parity),1(stop).
  - Model acks → single `done`, no `err`.
- **0xF4:**
  - Parity bit sampled must be 0.
  - ps2_clk_oe must be high for 10001 cycles after acceptance.
- **Device never clocks:**
  - `err` pulses exactly TIMEOUT_CYCLES cycles after REQ.
  - Both oe=0; tx_ready=1 the next cycle.
- **NACK (model leaves data high at the 11th fall):**
  - `err` pulses once.
  - `done` never asserts; block returns to IDLE after the bus goes idle.
- **Glitches and back-to-back requests:**
  - A 3-cycle low glitch on ps2_clk produces no bit advance.
  - `tx_valid`=1 with 0xAA mid-frame is ignored; the frame still carries the original byte.
- **Reset mid-frame:**
  - `rst` low after bit 4: both oe drop on the same edge as reset asserts.
  - After release, tx_ready=1, and a new 0xF4 transfer completes normally.
